// File: rtl/spi_reg_peripheral_pkg.sv
// Shared types and constants for the SPI register peripheral.
package spi_reg_peripheral_pkg;

  localparam int ADDR_W = 7;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

endpackage

// File: rtl/spi_reg_peripheral_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin, with one-cycle
// rise/fall pulses derived from the synchronised level.
module spi_reg_peripheral_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = (sync_q << 1) | STAGES'(d_i);
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 peripheral: {rw,addr} command byte followed by auto-incrementing
// data bytes that write or read a small register bank.
module spi_reg_peripheral
  import spi_reg_peripheral_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_cs_n,
  input  logic                      spi_sclk,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      spi_miso_oe,
  output logic [NUM_REGS*WIDTH-1:0] regs_o,
  output logic                      wr_strobe,
  output logic [ADDR_W-1:0]         wr_addr
);

  localparam int BIT_W = $clog2(WIDTH);

  logic cs_sync, cs_fall, cs_rise_unused;
  logic sclk_rise, sclk_fall, sclk_sync_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  // CS synchroniser resets to "selected" so a frame already in progress when
  // reset releases produces no falling edge; only a fresh CS high->low starts one.
  spi_reg_peripheral_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
    .clk(clk), .rst(rst), .d_i(spi_cs_n),
    .sync_o(cs_sync), .rise_o(cs_rise_unused), .fall_o(cs_fall)
  );

  spi_reg_peripheral_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d_i(spi_sclk),
    .sync_o(sclk_sync_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_reg_peripheral_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d_i(spi_mosi),
    .sync_o(mosi_sync), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e            state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-2:0]  shift_in_q, shift_in_d;
  logic [WIDTH-1:0]  shift_out_q, shift_out_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              load_pend_q, load_pend_d;
  logic              miso_q, miso_d;
  logic              armed_q, armed_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  regs_q [NUM_REGS];
  logic [WIDTH-1:0]  regs_d [NUM_REGS];

  logic [WIDTH-1:0]  rx_byte;
  logic [WIDTH-1:0]  rd_byte;
  logic              last_bit;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    load_pend_d = load_pend_q;
    miso_d      = miso_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    armed_d     = armed_q | cs_sync;
    rx_byte     = {shift_in_q, mosi_sync};
    last_bit    = (bit_cnt_q == BIT_W'(WIDTH-1));
    rd_byte     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) rd_byte = regs_q[i];
    end

    if (cs_sync) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = '0;
      load_pend_d = 1'b0;
      miso_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d    = ST_CMD;
            bit_cnt_d  = '0;
            shift_in_d = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            bit_cnt_d  = bit_cnt_q + 1'b1;
            shift_in_d = rx_byte[WIDTH-2:0];
            if (last_bit) begin
              state_d     = ST_DATA;
              rw_d        = rx_byte[WIDTH-1];
              addr_d      = rx_byte[ADDR_W-1:0];
              load_pend_d = (rx_byte[WIDTH-1] != RW_WRITE);
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            bit_cnt_d  = bit_cnt_q + 1'b1;
            shift_in_d = rx_byte[WIDTH-2:0];
            if (last_bit) begin
              addr_d = addr_q + 1'b1;
              if (rw_q == RW_WRITE) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (addr_q == ADDR_W'(i)) begin
                    regs_d[i]   = rx_byte;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = addr_q;
                  end
                end
              end else begin
                load_pend_d = 1'b1;
              end
            end
          end else if (sclk_fall && rw_q != RW_WRITE) begin
            // First falling edge of each read byte loads the shifter and
            // presents its MSB; later ones walk down the remaining bits.
            if (load_pend_q) begin
              shift_out_d = rd_byte;
              miso_d      = rd_byte[WIDTH-1];
              load_pend_d = 1'b0;
            end else begin
              miso_d      = shift_out_q[WIDTH-2];
              shift_out_d = shift_out_q << 1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      load_pend_q <= 1'b0;
      miso_q      <= 1'b0;
      armed_q     <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      load_pend_q <= load_pend_d;
      miso_q      <= miso_d;
      armed_q     <= armed_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_o[g*WIDTH +: WIDTH] = regs_q[g];
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = armed_q & ~cs_sync;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed plus randomized frames against a byte-level model of the
// register bank and the SPI frame protocol.
module tb_spi_reg_peripheral;

  localparam int NUM_REGS = 8;
  localparam int WIDTH    = 8;
  localparam int HALF     = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      spi_cs_n;
  logic                      spi_sclk;
  logic                      spi_mosi;
  logic                      spi_miso;
  logic                      spi_miso_oe;
  logic [NUM_REGS*WIDTH-1:0] regs_o;
  logic                      wr_strobe;
  logic [6:0]                wr_addr;

  spi_reg_peripheral #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .regs_o(regs_o), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_regs [NUM_REGS];
  logic [6:0] exp_q[$];
  logic [6:0] obs_wr_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_miso_q[$];

  always @(negedge clk) begin
    if (!rst && wr_strobe) obs_wr_q.push_back(wr_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < NUM_REGS; i++) f[i*8 +: 8] = model_regs[i];
    return f;
  endfunction

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    wait_clk(HALF);
    m = spi_miso;
    spi_sclk = 1'b1;
    wait_clk(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic frame_start();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    check("oe_selected", 64'(spi_miso_oe), 64'd1);
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(2*HALF);
    check("oe_deselected", 64'(spi_miso_oe), 64'd0);
  endtask

  // Expected effect of a frame, from the protocol rules only: full bytes count,
  // a trailing partial byte has no effect.
  task automatic model_frame(input int nbits);
    int         nfull;
    logic       rw;
    int         a;
    nfull = nbits / 8;
    exp_miso_q.delete();
    if (nfull == 0) return;
    rw = tx_q[0][7];
    a  = int'(tx_q[0][6:0]);
    exp_miso_q.push_back(8'h00);
    for (int k = 1; k < nfull; k++) begin
      if (rw) begin
        if (a < NUM_REGS) begin
          model_regs[a] = tx_q[k];
          exp_q.push_back(7'(a));
        end
        exp_miso_q.push_back(8'h00);
      end else begin
        exp_miso_q.push_back((a < NUM_REGS) ? model_regs[a] : 8'h00);
      end
      a = (a + 1) % 128;
    end
  endtask

  task automatic run_frame(input int nbits);
    logic [7:0] cur;
    logic [7:0] t;
    logic       m;
    cur = '0;
    rx_q.delete();
    frame_start();
    for (int i = 0; i < nbits; i++) begin
      t = tx_q[i/8];
      spi_bit(t[7 - (i % 8)], m);
      cur = {cur[6:0], m};
      if (i % 8 == 7) rx_q.push_back(cur);
    end
    frame_end();
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_miso_bytes"}, 64'(rx_q.size()), 64'(exp_miso_q.size()));
    for (int k = 0; k < rx_q.size() && k < exp_miso_q.size(); k++)
      check($sformatf("%s_miso%0d", tag, k), 64'(rx_q[k]), 64'(exp_miso_q[k]));
    check({tag, "_strobes"}, 64'(obs_wr_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < obs_wr_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s_wr_addr%0d", tag, k), 64'(obs_wr_q[k]), 64'(exp_q[k]));
    check({tag, "_regs"}, regs_o, model_flat());
    check({tag, "_miso_idle"}, 64'(spi_miso), 64'd0);
    obs_wr_q.delete();
    exp_q.delete();
  endtask

  task automatic do_frame(input string tag, input int nbits);
    model_frame(nbits);
    run_frame(nbits);
    compare_frame(tag);
  endtask

  initial begin
    logic [7:0] t;
    logic       m;
    int         nb;

    rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
    wait_clk(4);
    check("rst_regs", regs_o, 64'd0);
    check("rst_miso", 64'(spi_miso), 64'd0);
    check("rst_oe", 64'(spi_miso_oe), 64'd0);
    check("rst_strobe", 64'(wr_strobe), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    rst = 1'b0;
    wait_clk(8);
    obs_wr_q.delete();

    tx_q = '{8'h83, 8'hA5};                 do_frame("wr3", 16);
    check("wr3_reg3", 64'(regs_o[31:24]), 64'hA5);
    tx_q = '{8'h03, 8'h00};                 do_frame("rd3", 16);
    tx_q = '{8'h86, 8'h11, 8'h22, 8'h33};   do_frame("burst6", 32);
    tx_q = '{8'h80, 8'h3C};                 do_frame("wr0", 16);
    tx_q = '{8'h7F, 8'h00, 8'h00};          do_frame("rdwrap", 24);
    check("rdwrap_reg0", 64'(rx_q[2]), 64'h3C);
    tx_q = '{8'h81, 8'hFF};                 do_frame("abort1", 13);
    tx_q = '{8'h81, 8'h77};                 do_frame("wr1", 16);
    tx_q = '{8'h01, 8'h00, 8'h00};          do_frame("rd1", 24);

    // Reset in the middle of a write data byte; the tail of the frame must be ignored.
    tx_q = '{8'h82, 8'h5A};
    frame_start();
    for (int i = 0; i < 12; i++) begin
      t = tx_q[i/8];
      spi_bit(t[7 - (i % 8)], m);
    end
    rst = 1'b1;
    wait_clk(1);
    check("mid_rst_regs", regs_o, 64'd0);
    check("mid_rst_miso", 64'(spi_miso), 64'd0);
    check("mid_rst_oe", 64'(spi_miso_oe), 64'd0);
    check("mid_rst_strobe", 64'(wr_strobe), 64'd0);
    check("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
    obs_wr_q.delete();
    for (int i = 12; i < 16; i++) begin
      t = tx_q[i/8];
      spi_bit(t[7 - (i % 8)], m);
    end
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(2*HALF);
    check("post_rst_strobes", 64'(obs_wr_q.size()), 64'd0);
    check("post_rst_regs", regs_o, 64'd0);
    tx_q = '{8'h82, 8'h5A};                 do_frame("after_rst", 16);

    for (int r = 0; r < 14; r++) begin
      tx_q.delete();
      if ($urandom_range(0, 3) == 0) t = 8'(7'h7E + 7'($urandom_range(0, 1)));
      else t = 8'($urandom_range(0, NUM_REGS + 1));
      t[7] = 1'($urandom_range(0, 1));
      tx_q.push_back(t);
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) tx_q.push_back(8'($urandom_range(0, 255)));
      do_frame($sformatf("rand%0d", r), 8 * (nb + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
